intra_tap_accumulator: RTL

Consumer end of the multiple-constant-multiplier (MCM) stage in the intra angular datapath. It accepts one beat of LANES signed coefficient products per reference-sample tap. It sums the TAPS beats of a group per lane, then rounds, normalises (>>6) and clips each lane to an unsigned sample. One registered prediction-sample vector is emitted per group, with valid/ready handshakes on both sides.

---
 rtl/intra_acc_pkg.sv | 29 ++
 rtl/intra_tap_accumulator_if.sv | 31 +++
 rtl/intra_round_clip.sv | 38 +++
 rtl/intra_tap_accumulator.sv | 125 ++++++++++++
 4 files changed

// File: rtl/intra_acc_pkg.sv
// -----------------------------------------------------------------------------
// intra_acc_pkg
// Shared constants and types for the intra angular tap accumulator.
//   LANES    : products per beat / samples per group
//   TAPS     : beats per group (filter length)
//   PW       : signed product width
//   BITDEPTH : output sample width
//   SHIFT    : normalisation shift (rounding offset = 1 << (SHIFT-1))
// -----------------------------------------------------------------------------
package intra_acc_pkg;

    localparam int LANES    = 8;
    localparam int TAPS     = 4;
    localparam int PW       = 16;
    localparam int BITDEPTH = 8;
    localparam int SHIFT    = 6;

    // Accumulator width that keeps the sum of `taps` products exact.
    function automatic int acc_width(input int pw, input int taps);
        return pw + $clog2(taps);
    endfunction

    // HOLD: the output register carries a vector not yet taken downstream.
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } acc_state_e;

endpackage

// File: rtl/intra_tap_accumulator_if.sv
// -----------------------------------------------------------------------------
// intra_tap_accumulator_if
// Product-beat input stream and sample-vector output stream.
//   in_valid/in_ready/in_last/in_prod : beat stream from the MCM stage
//   out_valid/out_ready/out_sample    : clipped prediction-sample vector
//   err                               : sticky group-length error
// master = the environment around the accumulator, slave = the accumulator.
// -----------------------------------------------------------------------------
interface intra_tap_accumulator_if;
    import intra_acc_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic                      in_last;
    logic [LANES*PW-1:0]       in_prod;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*BITDEPTH-1:0] out_sample;
    logic                      err;

    modport master (
        output in_valid, in_last, in_prod, out_ready,
        input  in_ready, out_valid, out_sample, err
    );

    modport slave (
        input  in_valid, in_last, in_prod, out_ready,
        output in_ready, out_valid, out_sample, err
    );

endinterface

// File: rtl/intra_round_clip.sv
// -----------------------------------------------------------------------------
// intra_round_clip
// Combinational per-lane rounding, arithmetic normalising shift and clip to
// an unsigned sample.
//   sum_i    : signed lane sum (AW bits)
//   sample_o : clipped unsigned sample (BITDEPTH bits)
// -----------------------------------------------------------------------------
module intra_round_clip #(
    parameter int AW       = 18,
    parameter int SHIFT    = 6,
    parameter int BITDEPTH = 8
) (
    input  logic signed [AW-1:0]       sum_i,
    output logic        [BITDEPTH-1:0] sample_o
);

    // One guard bit so adding the offset to the largest exact sum cannot wrap.
    localparam int RW = AW + 1;
    localparam logic signed [RW-1:0] OFFSET = RW'(2 ** (SHIFT - 1));
    localparam logic signed [RW-1:0] MAXV   = RW'((2 ** BITDEPTH) - 1);

    logic signed [RW-1:0] biased;
    logic signed [RW-1:0] shifted;

    // NOTE: every output of a combinational block gets a value on every path
    // (default first); a missing branch would infer a latch.
    always_comb begin
        biased   = {sum_i[AW-1], sum_i} + OFFSET;
        shifted  = biased >>> SHIFT;
        sample_o = shifted[BITDEPTH-1:0];
        if (shifted[RW-1]) begin
            sample_o = '0;
        end else if (shifted > MAXV) begin
            sample_o = '1;
        end
    end

endmodule

// File: rtl/intra_tap_accumulator.sv
// -----------------------------------------------------------------------------
// intra_tap_accumulator
// Sums TAPS beats of LANES signed products per lane, then rounds, shifts and
// clips each lane; emits one registered sample vector per group.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : intra_tap_accumulator_if.slave (beat stream in, vector out, err)
// Optional build macro: INTRA_ACC_TAPCHK_EN enables the per-group beat
// counter driving the sticky err flag; without it err is tied low.
// -----------------------------------------------------------------------------
module intra_tap_accumulator
    import intra_acc_pkg::*;
(
    input logic                   clk,
    input logic                   rst_n,
    intra_tap_accumulator_if.slave bus
);

    localparam int AW = acc_width(PW, TAPS);

    acc_state_e                state_q;
    logic                      start_q;
    logic [LANES*BITDEPTH-1:0] sample_q;
    logic signed [AW-1:0]      acc_q [LANES];
    logic signed [AW-1:0]      acc_d [LANES];
    logic signed [AW-1:0]      sum   [LANES];
    logic [LANES*BITDEPTH-1:0] result;
    logic                      beat_fire;
    logic                      last_fire;

    // Only a last beat can be stalled, and only by an undrained full output.
    assign bus.in_ready = !bus.in_valid || !bus.in_last || (state_q != HOLD) || bus.out_ready;
    assign beat_fire    = bus.in_valid && bus.in_ready;
    assign last_fire    = beat_fire && bus.in_last;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [PW-1:0] prod;
        assign prod = bus.in_prod[i*PW +: PW];
        // A group start loads the product instead of adding to the old sum.
        assign sum[i] = (start_q ? '0 : acc_q[i]) + {{(AW-PW){prod[PW-1]}}, prod};

        intra_round_clip #(
            .AW       (AW),
            .SHIFT    (SHIFT),
            .BITDEPTH (BITDEPTH)
        ) u_round_clip (
            .sum_i    (sum[i]),
            .sample_o (result[i*BITDEPTH +: BITDEPTH])
        );
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            acc_d[i] = acc_q[i];
            if (beat_fire) begin
                acc_d[i] = bus.in_last ? '0 : sum[i];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ACC;
            start_q  <= 1'b1;
            sample_q <= '0;
            // NOTE: the accumulators are plain flops, not a RAM, so they take
            // the reset and a mid-group reset drops the partial sum.
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            acc_q <= acc_d;
            if (beat_fire) begin
                start_q <= bus.in_last;
            end
            // A new last beat overrides the drain, replacing the held vector.
            if (last_fire) begin
                state_q  <= HOLD;
                sample_q <= result;
            end else if (bus.out_ready) begin
                state_q  <= ACC;
            end
        end
    end

    assign bus.out_valid  = (state_q == HOLD);
    assign bus.out_sample = sample_q;

`ifdef INTRA_ACC_TAPCHK_EN
    localparam int CW = $clog2(TAPS + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_next;
    logic          err_q;

    assign cnt_next = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (beat_fire) begin
            if (bus.in_last) begin
                cnt_q <= '0;
                if (cnt_next != CW'(TAPS)) begin
                    err_q <= 1'b1;
                end
            end else begin
                cnt_q <= cnt_next;
                // TAPS-th beat without in_last: the group is already too long.
                if (cnt_next == CW'(TAPS)) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule
